lfsr_rand_server: RTL

Shared pseudo-random byte server. Owns one 8-bit one-to-many (Galois) LFSR, polynomial x^8+x^4+x^3+x^2+1, period 255. Round-robin arbitrates NREQ requesters and delivers one fresh byte per grant, advancing the LFSR STRIDE steps before each delivery so that no two requesters see correlated consecutive values. It sits between the random-number generator and the lab blocks that consume random stimulus.

---
 rtl/lfsr_pkg.sv | 27 ++
 rtl/lfsr8_galois.sv | 38 +++
 rtl/lfsr_rand_server.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the random byte server: FSM states, default seed
// and the Galois LFSR step for x^8+x^4+x^3+x^2+1.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    DELIVER = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_SEED = 8'hBD;

  // One Galois step: shift left, fold the old MSB into taps 0, 2, 3 and 4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    logic [7:0] n;
    n[0] = q[7];
    n[1] = q[0];
    n[2] = q[1] ^ q[7];
    n[3] = q[2] ^ q[7];
    n[4] = q[3] ^ q[7];
    n[5] = q[4];
    n[6] = q[5];
    n[7] = q[6];
    return n;
  endfunction

endpackage

// File: rtl/lfsr8_galois.sv
// 8-bit Galois LFSR register with synchronous load and step enables.
// Load takes priority over step; callers keep load_val nonzero.
module lfsr8_galois
  import lfsr_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/lfsr_rand_server.sv
// Round-robin server handing out one fresh LFSR byte per grant, stepping the
// shared LFSR STRIDE times before each delivery.
module lfsr_rand_server #(
  parameter int         NREQ   = 4,
  parameter int         STRIDE = 1,
  parameter logic [7:0] SEED   = lfsr_pkg::DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [7:0]      seed_in,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic [7:0]      data,
  output logic            busy
);
  import lfsr_pkg::*;

  localparam int IDXW = $clog2(NREQ);

  state_e          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] winner_q;
  logic [IDXW-1:0] winner_d;
  logic [IDXW-1:0] ptr_d;
  logic [7:0]      cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic            valid_q;
  logic            busy_q;
  logic            any_req;
  logic [IDXW:0]   idx;

  logic            lfsr_step;
  logic            lfsr_load;
  logic [7:0]      lfsr_load_val;
  logic [7:0]      lfsr_q;

  // Scan downward from the farthest offset so the closest request at or
  // after ptr is the last one to overwrite winner_d.
  always_comb begin
    winner_d = ptr_q;
    any_req  = 1'b0;
    idx      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (IDXW + 1)'(i);
      if (idx >= (IDXW + 1)'(NREQ)) begin
        idx = idx - (IDXW + 1)'(NREQ);
      end
      if (req[idx[IDXW-1:0]]) begin
        winner_d = idx[IDXW-1:0];
        any_req  = 1'b1;
      end
    end
  end

  assign ptr_d = (winner_q == IDXW'(NREQ - 1)) ? '0 : winner_q + 1'b1;

  assign lfsr_step     = (state_q == ADVANCE);
  assign lfsr_load     = (state_q == IDLE) && seed_load;
  assign lfsr_load_val = (seed_in == 8'h00) ? SEED : seed_in;

  lfsr8_galois #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  // valid/gnt are set on the edge entering DELIVER so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      gnt_q   <= '0;
      case (state_q)
        IDLE: begin
          if (!seed_load && any_req) begin
            winner_q <= winner_d;
            cnt_q    <= 8'(STRIDE - 1);
            state_q  <= ADVANCE;
            busy_q   <= 1'b1;
          end
        end
        ADVANCE: begin
          if (cnt_q == 8'd0) begin
            state_q         <= DELIVER;
            valid_q         <= 1'b1;
            gnt_q[winner_q] <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DELIVER: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign data  = lfsr_q;

endmodule
